int_issue_select: RTL

Oldest-first issue selector for the integer issue queue. It tracks which queue entries hold live instructions and their relative age, and picks one ready entry per cycle. It frees that entry in the queue the same cycle and presents it through a registered valid/ready stage to the ALU dispatch path. It replaces the fixed lowest-index pick, so old instructions cannot starve behind younger low-index entries.

---
 rtl/int_issue_select_pkg.sv | 11 +
 rtl/int_issue_select_if.sv | 23 ++
 rtl/int_issue_select_age_matrix.sv | 44 ++++
 rtl/priority_encoder.sv | 24 ++
 rtl/int_issue_select.sv | 131 +++++++++++++
 5 files changed

// File: rtl/int_issue_select_pkg.sv
// Shared integer issue-queue sizing and types.
// Imported by the issue selector, its handshake interface and the age matrix.
package int_issue_select_pkg;

  localparam int INT_QUEUE_SIZE       = 8;
  localparam int INT_QUEUE_SIZE_INDEX = 3;

  typedef logic [INT_QUEUE_SIZE-1:0]       int_queue_mask_t;
  typedef logic [INT_QUEUE_SIZE_INDEX-1:0] int_queue_index_t;

endpackage

// File: rtl/int_issue_select_if.sv
// Issue-register handshake toward the ALU dispatch path.
// master: issue_valid/issue_index out, fu_ready in; slave: the reverse.
interface int_issue_select_if #(
  parameter int INDEX_W = int_issue_select_pkg::INT_QUEUE_SIZE_INDEX
);

  logic               issue_valid;
  logic [INDEX_W-1:0] issue_index;
  logic               fu_ready;

  modport master (
    output issue_valid,
    output issue_index,
    input  fu_ready
  );

  modport slave (
    input  issue_valid,
    input  issue_index,
    output fu_ready
  );

endinterface

// File: rtl/int_issue_select_age_matrix.sv
// Age matrix: r_older[i][j] = entry i older than entry j; picks oldest cand.
// Ports: clk, rst_n, i_alloc_eff/i_alloc_index, i_live_keep, i_cand, o_oldest.
module age_matrix #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_alloc_eff,
  input  logic [IW-1:0] i_alloc_index,
  input  logic [N-1:0]  i_live_keep,
  input  logic [N-1:0]  i_cand,
  output logic [N-1:0]  o_oldest
);

  logic [N-1:0][N-1:0] r_older;

  // New entry is younger than every survivor; row cleared first so the
  // diagonal ends at live_keep[idx], which is 0 for a free slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_older <= '0;
    end else if (i_alloc_eff) begin
      for (int j = 0; j < N; j++) begin
        r_older[i_alloc_index][j] <= 1'b0;
        r_older[j][i_alloc_index] <= i_live_keep[j];
      end
    end
  end

  // Stale rows/columns of dead entries are masked by i_cand.
  always_comb begin
    o_oldest = '0;
    for (int i = 0; i < N; i++) begin
      logic v_blk;
      v_blk = 1'b0;
      for (int j = 0; j < N; j++) begin
        v_blk = v_blk | (i_cand[j] & r_older[j][i]);
      end
      o_oldest[i] = i_cand[i] & ~v_blk;
    end
  end

endmodule

// File: rtl/priority_encoder.sv
// Lowest-index priority encoder: i_vec -> o_index of lowest set bit.
// Ports: i_vec (W), o_index (IW), o_valid (any bit set).
module priority_encoder #(
  parameter int W  = 8,
  parameter int IW = 3
) (
  input  logic [W-1:0]  i_vec,
  output logic [IW-1:0] o_index,
  output logic          o_valid
);

  // Scan downward so the lowest set bit is the final assignment.
  always_comb begin
    o_index = '0;
    o_valid = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_index = IW'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_issue_select.sv
// Oldest-first integer issue selector with registered issue stage.
// Ports: clk, rst_n, alloc_*, ready_vec, flush_*, grant_*, occupancy,
// issue_if (master: issue_valid/issue_index out, fu_ready in).
// Macro AGE_SELECT_EN: age-ordered pick; undefined: lowest-index pick.
module int_issue_select
  import int_issue_select_pkg::*;
#(
  parameter int QUEUE_SIZE = INT_QUEUE_SIZE,
  parameter int INDEX_W    = INT_QUEUE_SIZE_INDEX
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_valid,
  input  logic [INDEX_W-1:0]    alloc_index,
  input  logic [QUEUE_SIZE-1:0] ready_vec,
  input  logic                  flush_valid,
  input  logic [QUEUE_SIZE-1:0] flush_mask,
  input  logic                  flush_issue,
  output logic                  grant_valid,
  output logic [INDEX_W-1:0]    grant_index,
  output logic [INDEX_W:0]      occupancy,
  int_issue_select_if.master    issue_if
);

  logic [QUEUE_SIZE-1:0] r_live;
  logic                  r_issue_valid;
  logic [INDEX_W-1:0]    r_issue_index;
  logic [INDEX_W:0]      r_occ;

  logic [QUEUE_SIZE-1:0] w_cand;
  logic [QUEUE_SIZE-1:0] w_pick_vec;
  logic [INDEX_W-1:0]    w_pick_index;
  logic                  w_pick_any;
  logic                  w_load;
  logic [QUEUE_SIZE-1:0] w_flush_vec;
  logic [QUEUE_SIZE-1:0] w_grant_vec;
  logic [QUEUE_SIZE-1:0] w_alloc_vec;
  logic [QUEUE_SIZE-1:0] w_live_keep;
  logic                  w_alloc_eff;
  logic [INDEX_W:0]      w_kill_cnt;
  logic [INDEX_W:0]      w_occ_next;

  assign w_cand      = r_live & ready_vec;
  assign w_load      = ~r_issue_valid | issue_if.fu_ready;
  assign w_flush_vec = {QUEUE_SIZE{flush_valid}} & flush_mask;
  assign w_alloc_eff = alloc_valid & ~w_flush_vec[alloc_index];

`ifdef AGE_SELECT_EN
  age_matrix #(
    .N  (QUEUE_SIZE),
    .IW (INDEX_W)
  ) u_age (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_alloc_eff   (w_alloc_eff),
    .i_alloc_index (alloc_index),
    .i_live_keep   (w_live_keep),
    .i_cand        (w_cand),
    .o_oldest      (w_pick_vec)
  );
`else
  assign w_pick_vec = w_cand;
`endif

  priority_encoder #(
    .W  (QUEUE_SIZE),
    .IW (INDEX_W)
  ) u_penc (
    .i_vec   (w_pick_vec),
    .o_index (w_pick_index),
    .o_valid (w_pick_any)
  );

  assign grant_valid = w_pick_any & w_load & ~flush_valid;
  assign grant_index = grant_valid ? w_pick_index : '0;

  always_comb begin
    w_grant_vec = '0;
    w_alloc_vec = '0;
    if (grant_valid) w_grant_vec[grant_index] = 1'b1;
    if (w_alloc_eff) w_alloc_vec[alloc_index] = 1'b1;
  end

  assign w_live_keep = r_live & ~w_grant_vec & ~w_flush_vec;

  always_comb begin
    w_kill_cnt = '0;
    for (int i = 0; i < QUEUE_SIZE; i++) begin
      w_kill_cnt = w_kill_cnt + (INDEX_W+1)'(r_live[i] & w_flush_vec[i]);
    end
  end

  // Grant is blocked during a flush, so grant and kill never overlap.
  assign w_occ_next = r_occ
                    + (INDEX_W+1)'(w_alloc_eff)
                    - (INDEX_W+1)'(grant_valid)
                    - w_kill_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_live <= '0;
      r_occ  <= '0;
    end else begin
      r_live <= w_live_keep | w_alloc_vec;
      r_occ  <= w_occ_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_issue_valid <= 1'b0;
      r_issue_index <= '0;
    end else begin
      if (flush_issue) r_issue_valid <= 1'b0;
      else if (w_load) r_issue_valid <= grant_valid;
      if (w_load) r_issue_index <= grant_index;
    end
  end

  assign issue_if.issue_valid = r_issue_valid;
  assign issue_if.issue_index = r_issue_index;
  assign occupancy            = r_occ;

  // An alloc killed by a same-cycle flush never writes, so it may
  // name a live slot.
  a_alloc_free: assert property (
    @(posedge clk) disable iff (!rst_n)
    (alloc_valid && !w_flush_vec[alloc_index]) |-> !r_live[alloc_index]
  ) else $error("alloc to live slot %0d", alloc_index);

endmodule
